// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle for counter_seq_ctrl.
//   master: drives the level commands (cmd_start/stop/load), load_val, limit,
//           dir, mode; observes count, state, busy, tick, wrap, done.
//   slave : the controller itself (mirror image of master).
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_start;
  logic             cmd_stop;
  logic             cmd_load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             tick;
  logic             wrap;
  logic             done;

  modport master (
    output cmd_start, cmd_stop, cmd_load, load_val, limit, dir, mode,
    input  count, state, busy, tick, wrap, done
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_load, load_val, limit, dir, mode,
    output count, state, busy, tick, wrap, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an event counter driven by level-type probe
// commands. Rising edges of cmd_stop/cmd_load/cmd_start (priority in that
// order) drive an IDLE/RUN/PAUSE/DONE FSM. In RUN a prescaler produces a
// count step every TICK_DIV cycles; the count goes up to `limit` or down to 0,
// then wraps (free-run) or parks in DONE (one-shot).
// Ports:
//   clk_125M : fabric clock, rising edge
//   reset    : synchronous, active-high
//   bus      : counter_seq_ctrl_if.slave (commands in, count/status out)
module counter_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 125000000
) (
  input  logic                clk_125M,
  input  logic                reset,
  counter_seq_ctrl_if.slave   bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             start_prev_q, stop_prev_q, load_prev_q;

  logic start_e, stop_e, load_e, term;

  assign start_e = bus.cmd_start & ~start_prev_q;
  assign stop_e  = bus.cmd_stop  & ~stop_prev_q;
  assign load_e  = bus.cmd_load  & ~load_prev_q;
  // Terminal test evaluated against the live dir/limit.
  assign term    = bus.dir ? (cnt_q == '0) : (cnt_q >= bus.limit);

  // State register. Edge-detect history follows the command levels even in
  // reset, so a level held across reset release is not seen as an edge.
  always_ff @(posedge clk_125M) begin
    start_prev_q <= bus.cmd_start;
    stop_prev_q  <= bus.cmd_stop;
    load_prev_q  <= bus.cmd_load;
    if (reset) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      psc_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      psc_q  <= psc_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // Next state. A stop edge swallows any load/start edge in the same cycle
  // even when it has no effect itself (IDLE).
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    psc_d  = psc_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (stop_e) begin
      case (st_q)
        S_RUN:           st_d = S_PAUSE;   // prescaler held
        S_PAUSE, S_DONE: st_d = S_IDLE;
        default:         st_d = st_q;
      endcase
    end else if (load_e) begin
      cnt_d = bus.load_val;
      psc_d = '0;
      st_d  = S_IDLE;
    end else if (start_e && st_q != S_RUN) begin
      st_d = S_RUN;
      if (st_q == S_DONE) begin
        cnt_d = bus.dir ? bus.limit : '0;
        psc_d = '0;
      end else if (st_q == S_IDLE) begin
        psc_d = '0;
      end
      // PAUSE resumes from the held prescaler value
    end else if (st_q == S_RUN) begin
      if (psc_q == PS_MAX) begin
        psc_d  = '0;
        tick_d = 1'b1;
        if (!term) begin
          cnt_d = bus.dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end else if (!bus.mode) begin
          cnt_d  = bus.dir ? bus.limit : '0;
          wrap_d = 1'b1;
        end else begin
          st_d = S_DONE;                    // count holds its terminal value
        end
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.count = cnt_q;
    bus.state = st_q;
    bus.busy  = (st_q == S_RUN);
    bus.done  = (st_q == S_DONE);
    bus.tick  = tick_q;
    bus.wrap  = wrap_q;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the board's 8-bit event counter. It turns level-type debug-probe commands (start, stop, load) into edge-qualified control actions. It runs a prescaled up/down count with a programmable terminal value, in free-run or one-shot mode. It sits between the VIO probe outputs and the counter display/probe inputs, on the single 125 MHz fabric clock.

Parameters:
WIDTH, 8, count/limit/load width
TICK_DIV, 125000000, clock cycles per count step (>=2); prescaler width = clog2(TICK_DIV)

Ports:
clk_125M  in  1  fabric clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_start  in  1  level; rising edge = start/resume/restart
cmd_stop  in  1  level; rising edge = pause/halt
cmd_load  in  1  level; rising edge = load count from load_val
load_val  in  WIDTH  value loaded on cmd_load edge
limit  in  WIDTH  terminal value for up-count, reload value for down-count
dir  in  1  0 = up, 1 = down
mode  in  1  0 = free-run (wrap), 1 = one-shot
count  out  WIDTH  current count
state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
busy  out  1  state==RUN
tick  out  1  one-cycle pulse on each count step
wrap  out  1  one-cycle pulse on free-run reload
done  out  1  level, high in DONE

Behaviour:
- Reset (synchronous, active-high): count=0, state=IDLE, busy=0, tick=0, wrap=0, done=0, prescaler=0.
- During reset, each edge-detect register loads the current cmd_* level, so a level held high through reset release does not trigger a command.
- Inputs are synchronous to clk_125M; no synchronisers.
- Edge = cmd & ~cmd_prev. The action takes effect at the same clock edge that first samples cmd high, and outputs show it from that edge on (1-cycle latency from input change).
- Simultaneous edges: priority stop > load > start. Lower-priority edges in the same cycle are discarded, not queued.
- load edge, any state: count=load_val, prescaler=0, done=0, state=IDLE.
- stop edge:
  - RUN → PAUSE; prescaler held.
  - PAUSE → IDLE.
  - DONE → IDLE.
  - IDLE: no effect.
  - count is always held.
- start edge:
  - IDLE → RUN, prescaler=0, count unchanged.
  - PAUSE → RUN, prescaler resumes from its held value.
  - DONE → RUN, count = 0 (dir=0) or limit (dir=1), prescaler=0, done=0.
  - RUN: ignored.
- Prescaler runs only in RUN. When it reaches TICK_DIV-1 it returns to 0 and tick=1 that cycle. The count action applies at that edge, so tick and the new count are visible together.
- dir, mode and limit are sampled live at each tick.
- Terminal test at tick: up uses count>=limit (unsigned); down uses count==0.
- Not terminal: count ± 1.
- Terminal, free-run: count reloads to 0 (up) or limit (down), wrap=1 for that cycle.
- Terminal, one-shot: count unchanged, state=DONE, done=1.
- One-shot reaching the terminal value by stepping (e.g. 2→3 with limit 3) stays in RUN. DONE is entered on the next tick, when the terminal condition holds. The final value therefore displays for one full tick period.
- limit=0, up, free-run: count stays 0, wrap on every tick.
- Load value above limit, up: first tick treated as terminal (reload 0 / DONE).
- Arithmetic is WIDTH-bit unsigned. No wrap other than the defined reloads; 8'hFF+1 is unreachable because terminal is checked first.
- Reset mid-RUN: all outputs take reset values after that edge; the in-flight prescale count is lost.

Test Plan:
1. TICK_DIV=4, limit=3, dir=0, mode=0, start edge → count 0,1,2,3,0,1 with tick every 4 cycles; wrap=1 only on the 3→0 cycle; busy=1 throughout.
2. load_val=2, dir=1, mode=1, load then start → count 2,1,0 on successive ticks. Next tick: state=11, done=1, busy=0, count holds 0. A further start edge → count=3 when limit=3, RUN, done=0.
3. Run until prescaler=2, stop edge → state=PAUSE, count frozen 10+ cycles. Start edge → first tick 2 cycles later (prescaler preserved). A second stop from PAUSE → IDLE.
4. In RUN, assert stop, load (load_val=9) and start rising in the same cycle → state=PAUSE, count unchanged, load ignored. Drop all three, then raise load alone → count=9, IDLE.
5. Hold cmd_start=1 through reset deassertion → stays IDLE, count=0. Drop and re-raise → RUN next edge. Assert reset while RUN with count=5 → count=0, state=IDLE, done=0 after that edge.
6. load_val=200, limit=100, dir=0, mode=0, start → first tick gives count=0, wrap=1. With mode=1 instead → first tick gives DONE, count stays 200.
